// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one shared NAND full adder, one bit per clock, LSB first.
// Optional macro SERIAL_ADDER_SUB_EN adds the `sub` port (A - B computed as A + ~B + 1).

module full_adder_nand (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic n1, n2, n3, hx, n4, n5, n6;

    // Classic nine-gate NAND full adder; n1 and n4 double as the carry terms.
    assign n1   = ~(x & y);
    assign n2   = ~(x & n1);
    assign n3   = ~(y & n1);
    assign hx   = ~(n2 & n3);
    assign n4   = ~(hx & cin);
    assign n5   = ~(hx & n4);
    assign n6   = ~(cin & n4);
    assign s    = ~(n5 & n6);
    assign cout = ~(n4 & n1);
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] psum;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_b;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] psum_nx;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q;
    assign fa_b = b_sh[0] ^ sub_q;
`else
    assign fa_b = b_sh[0];
`endif

    full_adder_nand u_fa (
        .x    (a_sh[0]),
        .y    (fa_b),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

    // Only WIDTH-1 partial bits are stored; the last S completes the word directly.
    assign psum_nx = {fa_s, psum};

    assign ready = (state == IDLE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q <= sub;
                        carry <= sub;
`else
                        carry <= 1'b0;
`endif
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    psum  <= psum_nx[WIDTH-1:1];
                    carry <= fa_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB on this edge
                        sum   <= psum_nx;
                        cout  <= fa_co;
                        ovf   <= carry ^ fa_co;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder sequencer that time-shares a single `full_adder_nand` instance to add two WIDTH-bit operands, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/done handshake. It is the first clocked block in the NAND-adder area, and the next step toward a multi-cycle ALU.

## Interface
- `WIDTH`, default 8: operand width in bits; legal values are 2..32.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request to begin an operation; sampled only while `ready`=1.
- `a` in WIDTH: operand A; captured on the accepting edge.
- `b` in WIDTH: operand B; captured on the accepting edge.
- `sub` in 1: subtract request; present only when SERIAL_ADDER_SUB_EN is defined; captured with the operands.
- `ready` out 1: high in IDLE only.
- `busy` out 1: high in RUN only.
- `done` out 1: one-cycle pulse, high in DONE only.
- `sum` out WIDTH: registered result.
- `cout` out 1: registered carry out of the MSB.
- `ovf` out 1: registered two's-complement overflow, computed as carry-into-MSB XOR carry-out.

## Operation
- FSM states are IDLE, RUN and DONE. Encoding is free, but `ready`, `busy` and `done` must decode directly from the state register.
- **IDLE → RUN** when `start`=1 at a clock edge:
  - load `a` and `b` into the shift registers;
  - set carry to 0, or to `sub` when the macro is defined;
  - clear the bit counter to 0.
- **RUN**, on every edge:
  - the full adder sees `a_sh[0]`, `b_sh[0]` (XOR `sub_q` when the macro is defined) and `carry`;
  - S is shifted into the MSB of the partial-sum register;
  - the A and B shift registers shift right by one;
  - `carry` takes Cout;
  - the counter increments.
- **RUN → DONE** on the edge that processes bit WIDTH-1 (counter = WIDTH-1). On that same edge:
  - `sum` takes the final shifted value;
  - `cout` takes the final Cout;
  - `ovf` takes carry-into-MSB XOR Cout.
- **DONE → IDLE** unconditionally on the next edge.
- `start` is ignored in RUN and DONE. No queuing and no restart.
- `sum`, `cout` and `ovf` hold their values until the next completion. They do not change during RUN.
- Reset values: state IDLE, so `ready`=1, `busy`=0, `done`=0. `sum`=0, `cout`=0, `ovf`=0. Shift registers, carry and counter are all 0.
- Reset asserted in RUN or DONE aborts the operation. No `done` pulse is emitted and the outputs return to their reset values on that edge.
- Changes on `a`, `b` or `sub` after the accepting edge have no effect on the operation in flight.

## Timing
- The accepting edge is E0 (`start`=1 in IDLE).
- Bits 0..WIDTH-1 are processed at edges E1..EWIDTH.
- `busy`=1 for exactly WIDTH cycles, between E0 and EWIDTH.
- `done`=1 and the results are valid in the single cycle after EWIDTH.
- `ready` returns to 1 after E(WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles. Back-to-back: holding `start` high continuously restarts at the first edge with `ready`=1.
- The full adder is purely combinational between registers. The critical path is one full adder plus the carry flip-flop setup.

## Configuration
- Macro SERIAL_ADDER_SUB_EN.
- **Defined:**
  - the `sub` port exists;
  - `sub`=1 computes A − B as A + ~B + 1;
  - `cout`=1 means no borrow (A ≥ B unsigned);
  - `ovf` flags signed overflow of the subtraction.
- **Undefined:**
  - no `sub` port and no `sub_q` register;
  - the initial carry is 0;
  - the block only adds.
- Cycle timing is identical in both builds.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** hold `rst` 2 cycles → `ready`=1, `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
- **Add:**
  - 100+55 → `done` pulse exactly 8 cycles after the accepting edge; `sum`=155, `cout`=0, `ovf`=1 (signed 100+55 overflows).
  - 200+100 → `sum`=44, `cout`=1.
  - 255+1 → `sum`=0, `cout`=1.
  - 127+1 → `sum`=128, `ovf`=1.
- **Ignored start:** pulse `start` with new operands at cycles 3 and 8 of an operation (mid-RUN and in DONE) → the result is unchanged; `busy` is high for exactly 8 cycles; only one `done` pulse.
- **Operand change:** change `a`/`b` during RUN → the result reflects the operands captured at E0. Then hold `start` high → the next operation is accepted the cycle after `done`, with `ready` high.
- **Reset mid-op:** assert `rst` at the 4th RUN cycle → no `done` pulse; `sum`/`cout`/`ovf` are 0; `ready`=1 the next cycle.
- **Subtract (SERIAL_ADDER_SUB_EN defined):**
  - 5−3 → `sum`=2, `cout`=1.
  - 3−5 → `sum`=254, `cout`=0.
  - 128−1 → `sum`=127, `ovf`=1.
  - Latency is identical to add.
